// File: rtl/dac_spi_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dac_spi_sequencer_pkg
//  Description : Shared state encodings, frame geometry, default DAC nibbles
//                and source-select codes for the DAC SPI sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package dac_spi_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int         C_FRAME_BITS   = 24;
    localparam int         C_SAMPLE_W     = 12;
    localparam logic [3:0] C_DEFAULT_CMD  = 4'b0011;
    localparam logic [3:0] C_DEFAULT_ADDR = 4'b1111;

    localparam logic [1:0] C_SRC_HOLD     = 2'b00;
    localparam logic [1:0] C_SRC_SQUARE   = 2'b01;
    localparam logic [1:0] C_SRC_SINE     = 2'b10;
    localparam logic [1:0] C_SRC_SINE_ALT = 2'b11;

    // DAC word: command, address, 12-bit sample, four pad bits
    function automatic logic [C_FRAME_BITS-1:0] build_word(
        input logic [3:0]            cmd,
        input logic [3:0]            addr,
        input logic [C_SAMPLE_W-1:0] sample
    );
        return {cmd, addr, sample, 4'b0000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dac_spi_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : dac_spi_sequencer_if
//  Description : Sample-source inputs and DAC SPI pins of the sequencer.
//                master = sequencer side, slave = generators/DAC side.
//  Revision    : 1.0  initial release
// ============================================================================
interface dac_spi_sequencer_if;
    import dac_spi_sequencer_pkg::*;

    logic [1:0]            src_sel;
    logic [C_SAMPLE_W-1:0] sig_sine;
    logic [C_SAMPLE_W-1:0] sig_square;
    logic                  sample_req;
    logic                  spi_sck;
    logic                  spi_mosi;
    logic                  dac_cs_n;
    logic                  busy;
    logic                  overrun;

    modport master (
        input  src_sel, sig_sine, sig_square,
        output sample_req, spi_sck, spi_mosi, dac_cs_n, busy, overrun
    );

    modport slave (
        output src_sel, sig_sine, sig_square,
        input  sample_req, spi_sck, spi_mosi, dac_cs_n, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/dac_spi_sequencer_sample_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sample_tick_gen
//  Description : Free-running 0..SAMPLE_DIV-1 counter; tick_o is high for the
//                single cycle the count sits at SAMPLE_DIV-1.
//  Revision    : 1.0  initial release
// ============================================================================
module sample_tick_gen #(
    parameter int SAMPLE_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int               CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Wrap at the last count so the tick period is exactly SAMPLE_DIV
    always_comb begin
        count_d = (count_q == C_LAST) ? '0 : count_q + CNT_W'(1);
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = (count_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/dac_spi_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dac_spi_sequencer
//  Description : On each sample tick, selects sine/square/held sample, builds
//                the 24-bit DAC word and shifts it MSB-first over SPI mode 0.
//                All pins are driven straight from registers.
//  Revision    : 1.0  initial release
// ============================================================================
module dac_spi_sequencer
    import dac_spi_sequencer_pkg::*;
#(
    parameter int         CLK_DIV    = 2,
    parameter int         SAMPLE_DIV = 1000,
    parameter logic [3:0] CMD        = C_DEFAULT_CMD,
    parameter logic [3:0] ADDR       = C_DEFAULT_ADDR
) (
    input  logic                clk,
    input  logic                rst,
    dac_spi_sequencer_if.master dac_io
);

    localparam int                HALF_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HALF_W-1:0] C_HALF_LAST = HALF_W'(CLK_DIV - 1);
    localparam logic [4:0]        C_LAST_BIT  = 5'(C_FRAME_BITS - 1);

    state_t                  state_q;
    logic [HALF_W-1:0]       half_q;
    logic [4:0]              bit_q;
    // Holds the bits still to be sent after the one currently on MOSI
    logic [C_FRAME_BITS-2:0] shreg_q;
    logic [C_SAMPLE_W-1:0]   last_q;
    logic                    sample_req_q;
    logic                    sck_q;
    logic                    mosi_q;
    logic                    cs_n_q;
    logic                    busy_q;
    logic                    overrun_q;

    logic                    tick;
    logic [C_SAMPLE_W-1:0]   sample_d;
    logic [C_FRAME_BITS-1:0] word_d;

    sample_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    // Source select: sine wins when both bits set, 00 repeats the last sample
    always_comb begin
        sample_d = last_q;
        case (dac_io.src_sel)
            C_SRC_SQUARE:               sample_d = dac_io.sig_square;
            C_SRC_SINE, C_SRC_SINE_ALT: sample_d = dac_io.sig_sine;
            default:                    sample_d = last_q;
        endcase
        word_d = build_word(CMD, ADDR, sample_d);
    end

    // Frame sequencer: IDLE -> LOAD -> SHIFT -> DONE, all pins registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            half_q       <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            last_q       <= '0;
            sample_req_q <= 1'b0;
            sck_q        <= 1'b0;
            mosi_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sample_req_q <= 1'b0;
            // Ticks are never queued; one landing mid-frame is only recorded
            if (tick && busy_q) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        state_q      <= ST_LOAD;
                        sample_req_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    shreg_q <= word_d[C_FRAME_BITS-2:0];
                    last_q  <= sample_d;
                    mosi_q  <= word_d[C_FRAME_BITS-1];
                    cs_n_q  <= 1'b0;
                    sck_q   <= 1'b0;
                    half_q  <= '0;
                    bit_q   <= '0;
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (half_q == C_HALF_LAST) begin
                        half_q <= '0;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                        end else begin
                            sck_q <= 1'b0;
                            if (bit_q == C_LAST_BIT) begin
                                // Last falling edge: release CS, park MOSI low
                                cs_n_q  <= 1'b1;
                                mosi_q  <= 1'b0;
                                state_q <= ST_DONE;
                            end else begin
                                bit_q   <= bit_q + 5'd1;
                                mosi_q  <= shreg_q[C_FRAME_BITS-2];
                                shreg_q <= {shreg_q[C_FRAME_BITS-3:0], 1'b0};
                            end
                        end
                    end else begin
                        half_q <= half_q + HALF_W'(1);
                    end
                end
                ST_DONE: begin
                    // CS-high guard time before the next frame may start
                    if (half_q == C_HALF_LAST) begin
                        half_q  <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        half_q <= half_q + HALF_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dac_io.sample_req = sample_req_q;
    assign dac_io.spi_sck    = sck_q;
    assign dac_io.spi_mosi   = mosi_q;
    assign dac_io.dac_cs_n   = cs_n_q;
    assign dac_io.busy       = busy_q;
    assign dac_io.overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_spi_sequencer
//  Description : Directed bench for dac_spi_sequencer. Instance A runs at
//                SAMPLE_DIV=200, instance B at SAMPLE_DIV=60 (overrun case).
//                SPI slave models capture each frame on CS release.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dac_spi_sequencer;

    localparam int CLK_PERIOD = 10;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #(CLK_PERIOD/2) clk = ~clk;

    dac_spi_sequencer_if a_if ();
    dac_spi_sequencer_if b_if ();

    dac_spi_sequencer #(
        .CLK_DIV    (2),
        .SAMPLE_DIV (200),
        .CMD        (4'b0011),
        .ADDR       (4'b1111)
    ) u_dut_a (
        .clk    (clk),
        .rst    (rst_a),
        .dac_io (a_if)
    );

    dac_spi_sequencer #(
        .CLK_DIV    (2),
        .SAMPLE_DIV (60),
        .CMD        (4'b0011),
        .ADDR       (4'b1111)
    ) u_dut_b (
        .clk    (clk),
        .rst    (rst_b),
        .dac_io (b_if)
    );

    // ---------------- SPI slave model, instance A ----------------
    logic [23:0] a_sh = '0;
    logic [23:0] a_frame = '0;
    int  a_bits = 0, a_frame_bits = 0, a_frames = 0;
    time a_t_prev = 0, a_t_last = 0;
    int  a_brun = 0, a_blen = 0;

    always @(negedge a_if.dac_cs_n) begin
        a_sh   = '0;
        a_bits = 0;
    end
    always @(posedge a_if.spi_sck) begin
        if (a_if.dac_cs_n === 1'b0) begin
            a_sh     = {a_sh[22:0], a_if.spi_mosi};
            a_bits   = a_bits + 1;
            a_t_prev = a_t_last;
            a_t_last = $time;
        end
    end
    always @(posedge a_if.dac_cs_n) begin
        if (a_bits > 0) begin
            a_frame      = a_sh;
            a_frame_bits = a_bits;
            a_frames     = a_frames + 1;
        end
        a_bits = 0;
    end
    always @(negedge clk) begin
        if (a_if.busy === 1'b1) begin
            a_brun = a_brun + 1;
        end else begin
            if (a_brun > 0) a_blen = a_brun;
            a_brun = 0;
        end
    end

    // ---------------- SPI slave model, instance B ----------------
    logic [23:0] b_sh = '0;
    logic [23:0] b_frame = '0;
    int b_bits = 0, b_frame_bits = 0, b_frames = 0;

    always @(negedge b_if.dac_cs_n) begin
        b_sh   = '0;
        b_bits = 0;
    end
    always @(posedge b_if.spi_sck) begin
        if (b_if.dac_cs_n === 1'b0) begin
            b_sh   = {b_sh[22:0], b_if.spi_mosi};
            b_bits = b_bits + 1;
        end
    end
    always @(posedge b_if.dac_cs_n) begin
        if (b_bits > 0) begin
            b_frame      = b_sh;
            b_frame_bits = b_bits;
            b_frames     = b_frames + 1;
        end
        b_bits = 0;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Posedges until sample_req seen (0 = timed out)
    task automatic wait_req_a(output int n);
        n = 0;
        for (int i = 1; i <= 1000; i++) begin
            @(posedge clk); #1;
            if (a_if.sample_req === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_req_b(output int n);
        n = 0;
        for (int i = 1; i <= 1000; i++) begin
            @(posedge clk); #1;
            if (b_if.sample_req === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_frame_a(output logic ok);
        int start;
        start = a_frames;
        ok    = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (a_frames != start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   n;
        logic ok;

        a_if.src_sel    = 2'b01;
        a_if.sig_square = 12'hABC;
        a_if.sig_sine   = 12'h111;
        b_if.src_sel    = 2'b10;
        b_if.sig_sine   = 12'h9AB;
        b_if.sig_square = 12'h000;

        // ---- overrun on instance B (SAMPLE_DIV=60 < frame length) ----
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b0;
        wait_req_b(n);
        chk("b_first_req", n, 60);
        chk("b_overrun_init", b_if.overrun, 1'b0);
        wait_req_b(n);
        chk("b_req_spacing1", n, 120);
        chk("b_overrun_set", b_if.overrun, 1'b1);
        chk("b_frames1", b_frames, 1);
        chk("b_frame1", b_frame, 24'h3F9AB0);
        chk("b_frame1_bits", b_frame_bits, 24);
        wait_req_b(n);
        chk("b_req_spacing2", n, 120);
        chk("b_overrun_sticky", b_if.overrun, 1'b1);
        chk("b_frames2", b_frames, 2);
        chk("b_frame2_bits", b_frame_bits, 24);
        rst_b = 1'b1;

        // ---- reset values and first-request latency on instance A ----
        @(posedge clk);
        #1 rst_a = 1'b0;
        chk("rst_cs_n", a_if.dac_cs_n, 1'b1);
        chk("rst_sck", a_if.spi_sck, 1'b0);
        chk("rst_mosi", a_if.spi_mosi, 1'b0);
        chk("rst_busy", a_if.busy, 1'b0);
        chk("rst_overrun", a_if.overrun, 1'b0);
        chk("rst_req", a_if.sample_req, 1'b0);
        wait_req_a(n);
        chk("first_req_latency", n, 200);
        chk("load_busy", a_if.busy, 1'b1);

        // ---- square frame ----
        wait_frame_a(ok);
        chk("sq_frame_seen", ok, 1'b1);
        chk("sq_frame", a_frame, 24'h3FABC0);
        chk("sq_bits", a_frame_bits, 24);
        chk("sck_period", 32'(a_t_last - a_t_prev), 32'(4 * CLK_PERIOD));
        repeat (4) @(negedge clk);
        chk("busy_len", a_blen, 99);
        chk("sq_overrun", a_if.overrun, 1'b0);

        // ---- sine priority with both select bits set ----
        a_if.src_sel    = 2'b11;
        a_if.sig_sine   = 12'h123;
        a_if.sig_square = 12'hFFF;
        wait_frame_a(ok);
        chk("prio_frame_seen", ok, 1'b1);
        chk("prio_frame", a_frame, 24'h3F1230);

        // ---- hold last sample with src_sel=00 ----
        a_if.src_sel    = 2'b00;
        a_if.sig_sine   = 12'h456;
        a_if.sig_square = 12'h789;
        wait_frame_a(ok);
        chk("hold_frame_seen", ok, 1'b1);
        chk("hold_frame", a_frame, 24'h3F1230);

        // ---- inputs change mid-SHIFT ----
        a_if.src_sel    = 2'b01;
        a_if.sig_square = 12'h5A5;
        wait_req_a(n);
        chk("mid_req_seen", n != 0, 1'b1);
        repeat (31) @(posedge clk);
        #1;
        a_if.src_sel    = 2'b10;
        a_if.sig_sine   = 12'h7E7;
        a_if.sig_square = 12'h000;
        wait_frame_a(ok);
        chk("mid_frame_seen", ok, 1'b1);
        chk("mid_frame_inflight", a_frame, 24'h3F5A50);
        wait_frame_a(ok);
        chk("mid_next_seen", ok, 1'b1);
        chk("mid_next_frame", a_frame, 24'h3F7E70);

        // ---- async reset after the 10th rising edge ----
        wait_req_a(n);
        chk("ar_req_seen", n != 0, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (a_bits == 10) begin
                ok = 1'b1;
                break;
            end
        end
        chk("ar_bit10_seen", ok, 1'b1);
        #2 rst_a = 1'b1;
        #1;
        chk("ar_cs_n", a_if.dac_cs_n, 1'b1);
        chk("ar_sck", a_if.spi_sck, 1'b0);
        chk("ar_busy", a_if.busy, 1'b0);
        chk("ar_partial_bits", a_frame_bits, 10);
        a_if.src_sel    = 2'b01;
        a_if.sig_square = 12'h321;
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b0;
        wait_req_a(n);
        chk("ar_req_latency", n, 200);
        wait_frame_a(ok);
        chk("ar_frame_seen", ok, 1'b1);
        chk("ar_frame", a_frame, 24'h3F3210);
        chk("ar_frame_bits", a_frame_bits, 24);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
